// File: rtl/serial_alu_pkg.sv
// Shared encodings for the bit-serial ALU controller: slice op codes and FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package serial_alu_pkg;

    localparam logic [1:0] OP_AND   = 2'b00;
    localparam logic [1:0] OP_OR    = 2'b01;
    localparam logic [1:0] OP_ARITH = 2'b10;
    localparam logic [1:0] OP_SLT   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // SLT is a full A-B pass; logic ops never invert B.
    function automatic logic eff_sub(input logic [1:0] op, input logic add_sub);
        logic s;
        s = 1'b0;
        if (op == OP_SLT)
            s = 1'b1;
        else if (op == OP_ARITH)
            s = add_sub;
        return s;
    endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Request/response bundle between a requester and the serial ALU controller.
// Start is a level request sampled only when the controller is idle; done is a one-cycle pulse.
interface serial_alu_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             add_sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, op, add_sub,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, a, b, op, add_sub,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/alu.sv
// Combinational 1-bit ALU slice: AND / OR / full-add (B optionally inverted) / pass-through less input.
// Zero latency; no flow control.
module alu
    import serial_alu_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_ci,
    input  logic       i_add_sub,
    input  logic [1:0] i_op,
    input  logic       i_i3,
    output logic       o_r,
    output logic       o_co
);
    logic w_b;
    logic w_sum;

    assign w_b   = i_b ^ i_add_sub;
    assign w_sum = i_a ^ w_b ^ i_ci;
    assign o_co  = (i_a & w_b) | (i_ci & (i_a ^ w_b));

    always_comb begin
        o_r = 1'b0;
        case (i_op)
            OP_AND:   o_r = i_a & w_b;
            OP_OR:    o_r = i_a | w_b;
            OP_ARITH: o_r = w_sum;
            default:  o_r = i_i3;
        endcase
    end
endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial controller for the 1-bit alu slice: WIDTH cycles busy after accept, done pulse one cycle later.
// No queueing: start is only sampled in IDLE, so a requester simply holds it until busy rises.
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_alu_ctrl_if.slave    bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic [1:0]         r_op;
    logic               r_sub;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_last;
    logic               w_sub;
    logic [1:0]         w_slice_op;
    logic               w_r;
    logic               w_co;
    logic               w_ovf_raw;
    logic [WIDTH-1:0]   w_res_nxt;
    logic               w_busy;
    logic               w_done;

    assign w_accept   = (r_state == IDLE) && bus.start;
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_sub      = eff_sub(bus.op, bus.add_sub);
    assign w_slice_op = (r_op == OP_SLT) ? OP_ARITH : r_op;
    assign w_ovf_raw  = r_carry ^ w_co;
    assign w_res_nxt  = {w_r, {(WIDTH-1){1'b0}}} | (r_res_sr >> 1);

    alu u_alu (
        .i_a       (r_a_sr[0]),
        .i_b       (r_b_sr[0]),
        .i_ci      (r_carry),
        .i_add_sub (r_sub),
        .i_op      (w_slice_op),
        .i_i3      (1'b0),
        .o_r       (w_r),
        .o_co      (w_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            RUN:     w_busy = 1'b1;
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_op     <= OP_AND;
            r_sub    <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            // Carry preloaded with the subtract flag supplies the +1 of the two's complement.
            r_a_sr   <= bus.a;
            r_b_sr   <= bus.b;
            r_res_sr <= '0;
            r_op     <= bus.op;
            r_sub    <= w_sub;
            r_carry  <= w_sub;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_res_sr <= w_res_nxt;
            r_carry  <= w_co;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                case (r_op)
                    OP_ARITH: begin
                        r_result <= w_res_nxt;
                        r_cout   <= w_co;
                        r_ovf    <= w_ovf_raw;
                    end
                    OP_SLT: begin
                        // Signed less-than is the sign of A-B corrected by overflow.
                        r_result <= {{(WIDTH-1){1'b0}}, w_r ^ w_ovf_raw};
                        r_cout   <= w_co;
                        r_ovf    <= 1'b0;
                    end
                    default: begin
                        r_result <= w_res_nxt;
                        r_cout   <= 1'b0;
                        r_ovf    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.result   = r_result;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl: word-level reference model feeds a scoreboard checked on each done pulse.
module tb_serial_alu_ctrl;
    import serial_alu_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_alu_ctrl_if #(.WIDTH(W)) bus_if ();

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   accept_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] op, input logic as);
        exp_t   e;
        logic [W:0] s;
        e = '0;
        case (op)
            OP_AND: e.res = a & b;
            OP_OR:  e.res = a | b;
            OP_ARITH: begin
                if (as) begin
                    s     = {1'b0, a} + {1'b0, ~b} + 1'b1;
                    e.ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
                end else begin
                    s     = {1'b0, a} + {1'b0, b};
                    e.ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
                end
                e.res  = s[W-1:0];
                e.cout = s[W];
            end
            default: begin
                e.res  = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
                e.cout = (a >= b);
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && bus_if.done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("done_without_accept", 32'(bus_if.done), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_result",   32'(bus_if.result),   32'(mon_e.res));
                check("sb_cout",     32'(bus_if.cout),     32'(mon_e.cout));
                check("sb_overflow", 32'(bus_if.overflow), 32'(mon_e.ovf));
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},     32'(bus_if.busy),     32'd0);
        check({tag, "_done"},     32'(bus_if.done),     32'd0);
        check({tag, "_result"},   32'(bus_if.result),   32'd0);
        check({tag, "_cout"},     32'(bus_if.cout),     32'd0);
        check({tag, "_overflow"}, 32'(bus_if.overflow), 32'd0);
    endtask

    // Drives one request and checks busy/done timing relative to the accept edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input logic as, input bit hold);
        @(negedge clk);
        bus_if.start   = 1'b1;
        bus_if.a       = a;
        bus_if.b       = b;
        bus_if.op      = op;
        bus_if.add_sub = as;
        sb_q.push_back(model(a, b, op, as));
        accept_cnt++;
        @(posedge clk);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            if (!hold) bus_if.start = 1'b0;
            check($sformatf("busy_c%0d", k), 32'(bus_if.busy), 32'd1);
            check($sformatf("nodone_c%0d", k), 32'(bus_if.done), 32'd0);
            if (hold) begin
                bus_if.a = W'($urandom);
                bus_if.b = W'($urandom);
            end
        end
        @(negedge clk);
        check("done_pulse", 32'(bus_if.done), 32'd1);
        check("busy_in_done", 32'(bus_if.busy), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.a       = '0;
        bus_if.b       = '0;
        bus_if.op      = OP_AND;
        bus_if.add_sub = 1'b0;
        #2;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(8'h7F, 8'h01, OP_ARITH, 1'b0, 1'b0);
        @(negedge clk);
        check("result_held", 32'(bus_if.result), 32'h80);
        check("done_gone", 32'(bus_if.done), 32'd0);

        run_op(8'h05, 8'h07, OP_ARITH, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, OP_SLT,   1'b0, 1'b0);
        run_op(8'h01, 8'h80, OP_SLT,   1'b1, 1'b0);
        run_op(8'hF0, 8'h3C, OP_AND,   1'b1, 1'b0);
        run_op(8'hF0, 8'h3C, OP_OR,    1'b0, 1'b0);

        // Start held across the whole operation with operands churning.
        run_op(8'h64, 8'h1E, OP_ARITH, 1'b0, 1'b1);
        run_op(8'h5A, 8'h33, OP_ARITH, 1'b1, 1'b0);

        // Reset in the fourth RUN cycle abandons the operation.
        @(negedge clk);
        bus_if.start   = 1'b1;
        bus_if.a       = 8'h33;
        bus_if.b       = 8'h44;
        bus_if.op      = OP_ARITH;
        bus_if.add_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_rst", 32'(bus_if.busy), 32'd1);
        rst = 1'b1;
        #1;
        check_outputs_zero("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            check("idle_after_rst", 32'(bus_if.busy), 32'd0);
        end

        run_op(8'h10, 8'h20, OP_ARITH, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_op(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        end

        @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'(accept_cnt));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial controller that drives the existing 1-bit `alu` slice. It turns one WIDTH-bit operation into WIDTH single-bit cycles, LSB first, and keeps the carry in a flip-flop between cycles. It latches operands on a start handshake and shifts one bit pair per cycle into the slice. It reassembles the result and reports carry, overflow and set-less-than.

## Interface
Parameters:
- WIDTH, 8: operand/result width; legal range 2..32.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request; sampled only in IDLE.
- a, input, WIDTH: operand A; latched on accepted start.
- b, input, WIDTH: operand B; latched on accepted start.
- op, input, 2: 00 AND, 01 OR, 10 ADD/SUB, 11 SLT (signed).
- add_sub, input, 1: 0 add, 1 subtract; used only for op=10.
- busy, output, 1: high while bits are being processed.
- done, output, 1: one-cycle pulse; result and flags valid.
- result, output, WIDTH: final word, held until the next accepted start.
- cout, output, 1: carry out of MSB (ADD/SUB/SLT); 0 for AND/OR.
- overflow, output, 1: signed overflow (ADD/SUB only); 0 otherwise.

## Operation
- FSM states:
  - IDLE: accepts `start`.
  - RUN: processes one bit per cycle.
  - DONE: asserts `done`, then returns to IDLE.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --bit counter == WIDTH-1--> DONE.
  - DONE --always--> IDLE.
- On accept:
  - Latch a, b, op and effective add_sub into shift registers and control registers.
  - Load carry FF with effective add_sub (+1 for two's complement).
  - Clear bit counter.
  - Clear the result shift register.
- SLT mapping:
  - Slice op forced to 10 and add_sub forced to 1, i.e. a full A−B pass.
  - Slice `i3` input tied 0.
- Each RUN cycle:
  - Slice inputs are a_sr[0], b_sr[0] and carry FF.
  - Shift slice `r` into result MSB; result shifts right.
  - Shift operands right.
  - Load carry FF with slice `co`.
  - Increment the bit counter.
- Last bit (counter == WIDTH-1):
  - Register `cout` = slice `co`.
  - Register `overflow` = carry-in XOR carry-out of the MSB slice.
  - For SLT, result = {WIDTH-1 zeros, sum_msb XOR overflow_raw}, `cout` = slice co, `overflow` output = 0.
  - For AND/OR, `cout` and `overflow` are forced to 0.
- Subtract convention: `cout`=1 means no borrow.
- `start` is ignored while in RUN or DONE; there is no queueing.
- Operand changes after accept have no effect.

## Timing
- Reset (async, any state):
  - FSM to IDLE.
  - busy=0, done=0, result=0, cout=0, overflow=0.
  - Carry FF, counter and shift registers cleared.
- Accept edge = edge E at which IDLE and start=1.
- busy=1 for cycles E+1 .. E+WIDTH (exactly WIDTH cycles).
- done=1 for exactly the single cycle E+WIDTH+1; busy=0 in that cycle.
- result, cout and overflow update at the last RUN edge and are stable while done=1 and thereafter.
- Earliest next accept is at the DONE-cycle edge + 1, i.e. start sampled in the first IDLE cycle.
- Start-to-start throughput: WIDTH+2 cycles.
- Reset asserted mid-RUN: the operation is abandoned and no done pulse occurs.
- After rst deasserts, the first accept can occur on the next edge.

## Structure
- Package `serial_alu_pkg` holds:
  - Op encodings: OP_AND=2'b00, OP_OR=2'b01, OP_ARITH=2'b10, OP_SLT=2'b11.
  - FSM state enum: IDLE, RUN, DONE.
- One sub-module instance: the existing 1-bit `alu` slice, which is the only datapath logic.
- Counter width is $clog2(WIDTH).

## Test plan
WIDTH=8 for all scenarios.
- ADD: a=8'h7F, b=8'h01, op=10, add_sub=0 -> result=8'h80, overflow=1, cout=0; busy high 8 cycles; done pulses 9 cycles after accept edge.
- SUB: a=8'h05, b=8'h07, op=10, add_sub=1 -> result=8'hFE, cout=0 (borrow), overflow=0.
- SLT signed: a=8'h80, b=8'h01, op=11 -> result=8'h01. Also a=8'h01, b=8'h80 -> result=8'h00.
- AND/OR: a=8'hF0, b=8'h3C -> AND result=8'h30, OR result=8'hFC; cout=0 and overflow=0 in both.
- Start held high through an operation with changing a/b -> exactly one done per accept. Result reflects the operands latched at accept. Next accept occurs on the first IDLE cycle.
- rst pulsed at RUN cycle 4 of an ADD -> all outputs 0 asynchronously, no done pulse; a subsequent 8'h10+8'h20 yields 8'h30.
